// File: rtl/exec_ctrl_pkg.sv
// Shared types and encodings for the execute-stage sequencer, its decoder and the ALU.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_DECODE    = 2'b01,
    S_EXECUTE   = 2'b10,
    S_WRITEBACK = 2'b11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_B = 2'b01;

endpackage

// File: rtl/exec_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7[5] to datapath controls.
module exec_decode
  import exec_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] aluctrl,
  output logic       alusrc,
  output logic [1:0] immsrc,
  output logic       is_branch,
  output logic       is_illegal
);

  always_comb begin
    aluctrl    = ALU_ADD;
    alusrc     = 1'b0;
    immsrc     = IMM_I;
    is_branch  = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        alusrc = (opcode == OP_I);
        case (funct3)
          3'b000:  aluctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  aluctrl = ALU_AND;
          3'b110:  aluctrl = ALU_OR;
          3'b010:  aluctrl = ALU_SLT;
          default: is_illegal = 1'b1;
        endcase
      end
      OP_B: begin
        // Only BEQ/BNE are resolvable from the EQ flag alone
        aluctrl = ALU_SUB;
        immsrc  = IMM_B;
        if (funct3 == 3'b000 || funct3 == 3'b001) is_branch  = 1'b1;
        else                                      is_illegal = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle execute sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Define EXEC_CTRL_PERF_EN to add retired/taken/illegal event counters.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  EQ,
  output logic [2:0]            ALUctrl,
  output logic                  ALUSrc,
  output logic [1:0]            ImmSrc,
  output logic                  WE3,
  output logic                  PCSrc,
  output logic                  done,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] instr_q
`ifdef EXEC_CTRL_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] retired_cnt,
  output logic [DATA_WIDTH-1:0] taken_cnt,
  output logic [DATA_WIDTH-1:0] illegal_cnt
`endif
);

  state_t     state, state_n;
  logic [2:0] dec_aluctrl;
  logic       dec_alusrc;
  logic [1:0] dec_immsrc;
  logic       dec_branch;
  logic       dec_illegal;

  exec_decode u_decode (
    .opcode     (instr_q[6:0]),
    .funct3     (instr_q[14:12]),
    .funct7b5   (instr_q[30]),
    .aluctrl    (dec_aluctrl),
    .alusrc     (dec_alusrc),
    .immsrc     (dec_immsrc),
    .is_branch  (dec_branch),
    .is_illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (instr_valid) state_n = S_DECODE;
      S_DECODE:    state_n = dec_illegal ? S_IDLE : S_EXECUTE;
      S_EXECUTE:   state_n = dec_branch ? S_IDLE : S_WRITEBACK;
      S_WRITEBACK: state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Pulses are masked by rst so an abandoned instruction never writes or retires
  always_comb begin
    instr_ready = (state == S_IDLE);
    illegal     = !rst && (state == S_DECODE) && dec_illegal;
    PCSrc       = !rst && (state == S_EXECUTE) && dec_branch && (instr_q[12] ? !EQ : EQ);
    done        = !rst && (((state == S_EXECUTE) && dec_branch) || (state == S_WRITEBACK));
    WE3         = !rst && (state == S_WRITEBACK) && (instr_q[11:7] != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      ALUctrl <= ALU_ADD;
      ALUSrc  <= 1'b0;
      ImmSrc  <= IMM_I;
    end else begin
      if (state == S_IDLE && instr_valid) instr_q <= instr;
      if (state == S_DECODE && !dec_illegal) begin
        ALUctrl <= dec_aluctrl;
        ALUSrc  <= dec_alusrc;
        ImmSrc  <= dec_immsrc;
      end
    end
  end

`ifdef EXEC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      taken_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      retired_cnt <= retired_cnt + {{(DATA_WIDTH-1){1'b0}}, done};
      taken_cnt   <= taken_cnt   + {{(DATA_WIDTH-1){1'b0}}, PCSrc};
      illegal_cnt <= illegal_cnt + {{(DATA_WIDTH-1){1'b0}}, illegal};
    end
  end
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: per-instruction timeline model plus literal spot checks.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        EQ;
  logic [2:0]  ALUctrl;
  logic        ALUSrc;
  logic [1:0]  ImmSrc;
  logic        WE3, PCSrc, done, illegal;
  logic [31:0] instr_q;
`ifdef EXEC_CTRL_PERF_EN
  logic [31:0] retired_cnt, taken_cnt, illegal_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exec_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .EQ(EQ), .ALUctrl(ALUctrl), .ALUSrc(ALUSrc),
    .ImmSrc(ImmSrc), .WE3(WE3), .PCSrc(PCSrc), .done(done), .illegal(illegal),
    .instr_q(instr_q)
`ifdef EXEC_CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .taken_cnt(taken_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set table
  task automatic ref_dec(input logic [31:0] ins, output logic ill, output logic br,
                         output logic [2:0] alu, output logic src, output logic [1:0] imm);
    logic [2:0] f3;
    f3 = ins[14:12];
    ill = 1'b0; br = 1'b0; alu = 3'd0; src = 1'b0; imm = 2'd0;
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      src = (ins[6:0] == 7'h13);
      if (f3 == 3'd0)      alu = (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
      else if (f3 == 3'd7) alu = 3'd2;
      else if (f3 == 3'd6) alu = 3'd3;
      else if (f3 == 3'd2) alu = 3'd5;
      else                 ill = 1'b1;
    end else if (ins[6:0] == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
      br = 1'b1; alu = 3'd1; imm = 2'd1;
    end else begin
      ill = 1'b1;
    end
  endtask

  // Model: whether an instruction is in flight and how many cycles since accept
  logic        m_busy = 1'b0;
  int          m_age  = 0;
  logic [31:0] m_iq   = '0;
  logic [2:0]  m_alu  = '0;
  logic        m_src  = 1'b0;
  logic [1:0]  m_imm  = '0;
  logic [31:0] m_ret = '0, m_tak = '0, m_ill = '0;
  logic        chk_en = 1'b0;
  logic        e_rdy, e_ill, e_pc, e_done, e_we3;

  task automatic model_outs();
    logic ill, br, src;
    logic [2:0] alu;
    logic [1:0] imm;
    ref_dec(m_iq, ill, br, alu, src, imm);
    e_rdy  = !m_busy;
    e_ill  = m_busy && !rst && m_age == 1 && ill;
    e_pc   = m_busy && !rst && m_age == 2 && br && (m_iq[12] ? !EQ : EQ);
    e_done = m_busy && !rst && ((m_age == 2 && br) || (m_age == 3 && !br && !ill));
    e_we3  = m_busy && !rst && m_age == 3 && !br && !ill && (m_iq[11:7] != 5'd0);
  endtask

  always @(posedge clk) begin
    logic ill, br, src;
    logic [2:0] alu;
    logic [1:0] imm;
    model_outs();
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_iq = '0; m_alu = '0; m_src = 1'b0; m_imm = '0;
      m_ret = '0; m_tak = '0; m_ill = '0;
      chk_en = 1'b1;
    end else begin
      m_ret = m_ret + 32'(e_done);
      m_tak = m_tak + 32'(e_pc);
      m_ill = m_ill + 32'(e_ill);
      if (m_busy) begin
        if (e_ill || e_done) m_busy = 1'b0;
        else begin
          if (m_age == 1) begin
            ref_dec(m_iq, ill, br, alu, src, imm);
            m_alu = alu; m_src = src; m_imm = imm;
          end
          m_age++;
        end
      end else if (instr_valid) begin
        m_busy = 1'b1; m_age = 1; m_iq = instr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      model_outs();
      chk("instr_ready", 32'(instr_ready), 32'(e_rdy));
      chk("illegal",     32'(illegal),     32'(e_ill));
      chk("PCSrc",       32'(PCSrc),       32'(e_pc));
      chk("done",        32'(done),        32'(e_done));
      chk("WE3",         32'(WE3),         32'(e_we3));
      chk("ALUctrl",     32'(ALUctrl),     32'(m_alu));
      chk("ALUSrc",      32'(ALUSrc),      32'(m_src));
      chk("ImmSrc",      32'(ImmSrc),      32'(m_imm));
      chk("instr_q",     instr_q,          m_iq);
`ifdef EXEC_CTRL_PERF_EN
      chk("retired_cnt", retired_cnt, m_ret);
      chk("taken_cnt",   taken_cnt,   m_tak);
      chk("illegal_cnt", illegal_cnt, m_ill);
`endif
    end
  end

  // Per-cycle observations of the last run, cycle 0 = accept cycle
  logic [4:0]  o_we3, o_done, o_pc, o_ill, o_rdy, o_src;
  logic [2:0]  o_alu [5];
  logic [31:0] o_iq  [5];

  task automatic run(input logic [31:0] ins, input logic eq, input int rst_at);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      instr_valid = (k == 0);
      instr       = (k == 0) ? ins : 32'hFFFF_FFFF;
      EQ          = eq;
      rst         = (k == rst_at);
      @(negedge clk);
      o_we3[k] = WE3; o_done[k] = done; o_pc[k] = PCSrc; o_ill[k] = illegal;
      o_rdy[k] = instr_ready; o_src[k] = ALUSrc; o_alu[k] = ALUctrl; o_iq[k] = instr_q;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADDI  = 32'h00700293;
  localparam logic [31:0] I_ADDI0 = 32'h00100013;
  localparam logic [31:0] I_SUB   = 32'h40208233;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  logic [31:0] stream [6];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    logic acc;
    rst = 1'b1; instr = '0; instr_valid = 1'b0; EQ = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset instr_ready", 32'(instr_ready), 32'd1);
    chk("reset ALUctrl",     32'(ALUctrl),     32'd0);
    chk("reset instr_q",     instr_q,          32'd0);
    chk("reset WE3|done",    32'(WE3 | done | PCSrc | illegal), 32'd0);

    run(I_ADD, 1'b0, -1);
    chk("add ALUctrl c2",  32'(o_alu[2]), 32'd0);
    chk("add ALUSrc c3",   32'(o_src[3]), 32'd0);
    chk("add WE3 timing",  32'(o_we3),    32'b01000);
    chk("add done timing", 32'(o_done),   32'b01000);
    chk("add ready",       32'(o_rdy),    32'b10001);
    chk("add instr_q c3",  o_iq[3],       I_ADD);

    run(I_ADDI, 1'b0, -1);
    chk("addi ALUSrc c2",  32'(o_src[2]), 32'd1);
    chk("addi WE3 timing", 32'(o_we3),    32'b01000);

    run(I_ADDI0, 1'b0, -1);
    chk("addi x0 done", 32'(o_done), 32'b01000);
    chk("addi x0 WE3",  32'(o_we3),  32'd0);

    run(I_BEQ, 1'b1, -1);
    chk("beq PCSrc", 32'(o_pc),   32'b00100);
    chk("beq done",  32'(o_done), 32'b00100);
    chk("beq WE3",   32'(o_we3),  32'd0);
    chk("beq ALUctrl", 32'(o_alu[2]), 32'd1);

    run(I_BNE, 1'b1, -1);
    chk("bne PCSrc", 32'(o_pc),   32'd0);
    chk("bne done",  32'(o_done), 32'b00100);

    run(I_ILL, 1'b0, -1);
    chk("ill pulse",  32'(o_ill),  32'b00010);
    chk("ill done",   32'(o_done | o_we3), 32'd0);
    chk("ill ready2", 32'(o_rdy[2]), 32'd1);

    run(I_SUB, 1'b0, 3);
    chk("sub ALUctrl c2", 32'(o_alu[2]), 32'd1);
    chk("sub rst WE3",    32'(o_we3),    32'd0);
    chk("sub rst done",   32'(o_done),   32'd0);
    chk("sub rst ALUctrl c4", 32'(o_alu[4]), 32'd0);
    chk("sub rst instr_q c4", o_iq[4], 32'd0);
`ifdef EXEC_CTRL_PERF_EN
    chk("sub rst retired_cnt", retired_cnt, 32'd0);
`endif

    // Extra decode coverage checked by the model
    run(32'h0020F1B3, 1'b0, -1);  // AND
    run(32'h00706293, 1'b0, -1);  // ORI
    run(32'h0020A1B3, 1'b0, -1);  // SLT
    run(32'h002091B3, 1'b0, -1);  // R-type funct3 001
    run(32'h0020A463, 1'b1, -1);  // branch funct3 010
    run(I_BEQ, 1'b0, -1);
    run(I_BNE, 1'b0, -1);

    // Back-to-back stream with instr_valid held high, counters cleared first
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    stream[0] = I_ADD; stream[1] = I_ADD; stream[2] = I_ADD;
    stream[3] = I_BEQ; stream[4] = I_BEQ; stream[5] = I_ILL;
    idx = 0; instr = stream[0]; instr_valid = 1'b1; EQ = 1'b1;
    for (int c = 0; c < 60 && idx < 6; c++) begin
      @(negedge clk);
      acc = instr_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 6) instr = stream[idx];
        else instr_valid = 1'b0;
      end
    end
    chk("stream accepted", 32'(idx), 32'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
`ifdef EXEC_CTRL_PERF_EN
    chk("stream retired_cnt", retired_cnt, 32'd5);
    chk("stream taken_cnt",   taken_cnt,   32'd2);
    chk("stream illegal_cnt", illegal_cnt, 32'd1);
`endif
    chk("stream model retired", m_ret, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Multi-cycle sequencer for the execute datapath: register file, ALUSrc mux and ALU. It accepts one instruction word at a time over a valid/ready handshake and decodes R-type, I-type ALU and BEQ/BNE. It then steps the datapath through DECODE, EXECUTE and WRITEBACK, driving ALUctrl, ALUSrc, WE3 and ImmSrc, and it resolves branches from the ALU EQ flag. It sits between the fetch/instruction source and the execute datapath, replacing hard-wired single-cycle control.

## Interface
- DATA_WIDTH, 32, instruction word and counter width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instr  input  DATA_WIDTH  instruction word; sampled on accept
- instr_valid  input  1  instr holds a valid instruction
- instr_ready  output  1  controller can accept; high only in IDLE
- EQ  input  1  ALU equality flag (ALU result == 0)
- ALUctrl  output  3  ALU operation
- ALUSrc  output  1  0 = RD2, 1 = ImmExt
- ImmSrc  output  2  00 = I-type, 01 = B-type
- WE3  output  1  register file write enable, one-cycle pulse
- PCSrc  output  1  branch taken, one-cycle pulse
- done  output  1  instruction retired, one-cycle pulse
- illegal  output  1  unsupported opcode/funct, one-cycle pulse
- instr_q  output  DATA_WIDTH  latched instruction; register addresses come from bits 19:15, 24:20 and 11:7

## Operation
- States: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: instr_ready=1. When instr_valid is high, latch instr into instr_q and go to DECODE.
- DECODE: classify by opcode[6:0]:
  - 0110011 is R-type.
  - 0010011 is I-type ALU.
  - 1100011 with funct3 000 (BEQ) or 001 (BNE) is a branch.
  - Anything else pulses illegal and returns to IDLE, with no WE3, no done and no PCSrc.
- ALUctrl encoding: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
- R-type decode:
  - funct3 000 with funct7[5]=0 is ADD.
  - funct3 000 with funct7[5]=1 is SUB.
  - funct3 111 is AND, 110 is OR, 010 is SLT.
  - Any other funct3 is illegal.
- I-type decode: same funct3 map with ADD fixed (funct7 ignored), ALUSrc=1, ImmSrc=00.
- Branch decode: ALUctrl=SUB, ALUSrc=0, ImmSrc=01.
- ALUctrl, ALUSrc and ImmSrc are registered. They are set on the DECODE→EXECUTE edge and held stable through WRITEBACK.
- EXECUTE:
  - Branch: PCSrc = EQ for BEQ, PCSrc = !EQ for BNE. Pulse done, go to IDLE.
  - ALU op: go to WRITEBACK.
- WRITEBACK: WE3=1 unless rd (instr_q[11:7]) == 0, in which case the write is suppressed. Pulse done, go to IDLE.
- instr is ignored outside IDLE; instr_q changes only on accept.

## Timing
- Reset values: state IDLE, instr_ready=1, ALUctrl=000, ALUSrc=0, ImmSrc=00, WE3=0, PCSrc=0, done=0, illegal=0, instr_q=0.
- Accept happens in cycle 0, on the clk edge with instr_valid & instr_ready.
- DECODE is cycle 1; illegal, if any, pulses here.
- EXECUTE is cycle 2; PCSrc and done pulse here for branches.
- WRITEBACK is cycle 3; WE3 and done pulse here for ALU ops.
- Throughput: ALU op every 4 cycles, branch every 3, illegal every 2.
- WE3 is asserted for exactly one cycle, while ALUResult is stable under the held controls. The register file commits on the following clk edge.
- rst in any state (including WRITEBACK) returns to IDLE on that edge:
  - all outputs go to reset values;
  - the in-flight instruction is abandoned with no write, no done and no PCSrc.
- instr_valid held high continuously: the next instruction is accepted in the first IDLE cycle after done/illegal.

## Configuration
- EXEC_CTRL_PERF_EN defined adds three outputs, each DATA_WIDTH wide:
  - retired_cnt: increments on done.
  - taken_cnt: increments on PCSrc.
  - illegal_cnt: increments on illegal.
- All three counters reset to 0 on rst, wrap modulo 2^DATA_WIDTH, and update on the edge after the pulse.
- Undefined: the three ports and counters do not exist; core behaviour is identical.

## Structure
- Package exec_ctrl_pkg holds:
  - the state enum;
  - ALUctrl constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
  - opcode constants (OP_R, OP_I, OP_B);
  - ImmSrc constants.
- The ALU module imports the same ALUctrl constants.
- One sub-module, exec_decode: combinational opcode/funct3/funct7 → {ALUctrl, ALUSrc, ImmSrc, is_branch, is_illegal}.
- The FSM, output registers and perf counters live in exec_ctrl.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) accepted in cycle 0 → ALUctrl=000, ALUSrc=0 in cycles 2–3; WE3 and done high in cycle 3 only; instr_ready high again in cycle 4.
- ADDI x5,x0,7 (0x00700293) → ALUSrc=1, ImmSrc=00, ALUctrl=000; WE3 pulse in cycle 3. ADDI x0,x0,1 (0x00100013) → done in cycle 3 with WE3=0.
- BEQ with EQ=1 → PCSrc and done in cycle 2, WE3 never asserted. BNE with EQ=1 → PCSrc=0, done in cycle 2.
- Opcode 0x0000007F → illegal in cycle 1, no done/WE3; next valid instruction accepted in cycle 2.
- rst asserted in WRITEBACK cycle of SUB x4,x1,x2 → WE3=0 that cycle; all outputs at reset values the next cycle; with EXEC_CTRL_PERF_EN, retired_cnt=0.
- With EXEC_CTRL_PERF_EN, back-to-back stream of 3 ADD, 2 taken BEQ, 1 illegal → retired_cnt=5, taken_cnt=2, illegal_cnt=1.
